// File: rtl/dcm_spi_pkg.sv
// Shared types and width helpers for the dcmctrl SPI scheduler.
package dcm_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    // Counter width able to hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Requester index width, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcm_rr_arbiter.sv
// Round-robin grant: first requester after ptr, wrapping, gated by en.
module dcm_rr_arbiter
    import dcm_spi_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [id_w(N_REQ)-1:0]   ptr,
    input  logic                     en,
    output logic [N_REQ-1:0]         grant,
    output logic [id_w(N_REQ)-1:0]   idx
);

    localparam int IW = id_w(N_REQ);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/dcm_spi_sched.sv
// SPI mode-0 master shared round-robin between N_REQ frame requesters.
module dcm_spi_sched
    import dcm_spi_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int N_BYTES = 3,
    parameter int CLK_DIV = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*8*N_BYTES-1:0]   req_data,
    output logic                         rsp_valid,
    output logic [id_w(N_REQ)-1:0]       rsp_id,
    output logic [8*N_BYTES-1:0]         rsp_data,
    output logic                         spi_ss,
    output logic                         spi_clk,
    output logic                         spi_mosi,
    input  logic                         spi_miso
);

    localparam int B  = 8 * N_BYTES;
    localparam int IW = id_w(N_REQ);
    localparam int DW = cnt_w(CLK_DIV);
    localparam int BW = cnt_w(B);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(B - 1);

    state_t state, state_n;

    logic [DW-1:0]    div_cnt, div_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [B-1:0]     tx, tx_n, rx, rx_n, frame, rsp_data_n;
    logic [IW-1:0]    ptr, ptr_n, id, id_n, gnt_idx, rsp_id_n;
    logic [N_REQ-1:0] gnt;
    logic             hs, div_last, bit_last, hi_end, lo_end;
    logic             ss_n, sclk_n, mosi_n, rsp_valid_n;

    dcm_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (state == IDLE),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    assign req_ready = gnt;
    assign hs        = |gnt;
    assign frame     = req_data[int'(gnt_idx)*B +: B];
    assign div_last  = (div_cnt == DIV_LAST);
    assign bit_last  = (bit_cnt == BIT_LAST);
    assign hi_end    = (state == SHIFT) && spi_clk && div_last;
    assign lo_end    = (state == SHIFT) && !spi_clk && div_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (hs) state_n = SETUP;
            SETUP: if (div_last) state_n = SHIFT;
            SHIFT: if (lo_end && bit_last) state_n = GAP;
            GAP:   if (div_last) state_n = IDLE;
        endcase
    end

    always_comb begin
        div_n       = (state == IDLE || div_last) ? '0 : div_cnt + 1'b1;
        bit_n       = bit_cnt;
        tx_n        = tx;
        rx_n        = rx;
        ptr_n       = ptr;
        id_n        = id;
        ss_n        = spi_ss;
        sclk_n      = spi_clk;
        mosi_n      = spi_mosi;
        rsp_valid_n = 1'b0;
        rsp_id_n    = rsp_id;
        rsp_data_n  = rsp_data;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    tx_n   = frame;
                    id_n   = gnt_idx;
                    ptr_n  = gnt_idx;
                    bit_n  = '0;
                    ss_n   = 1'b0;
                    mosi_n = frame[B-1];
                end
            end
            SETUP: begin
                if (div_last) sclk_n = 1'b1;
            end
            SHIFT: begin
                if (hi_end) begin
                    sclk_n = 1'b0;
                    rx_n   = {rx[B-2:0], spi_miso};
                    // Last bit keeps mosi stable through its low half.
                    if (!bit_last) begin
                        tx_n   = {tx[B-2:0], 1'b0};
                        mosi_n = tx[B-2];
                    end
                end else if (lo_end) begin
                    if (bit_last) begin
                        ss_n        = 1'b1;
                        mosi_n      = 1'b0;
                        rsp_valid_n = 1'b1;
                        rsp_id_n    = id;
                        rsp_data_n  = rx;
                    end else begin
                        sclk_n = 1'b1;
                        bit_n  = bit_cnt + 1'b1;
                    end
                end
            end
            GAP: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            ptr       <= IW'(N_REQ - 1);
            id        <= '0;
            spi_ss    <= 1'b1;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            div_cnt   <= div_n;
            bit_cnt   <= bit_n;
            tx        <= tx_n;
            rx        <= rx_n;
            ptr       <= ptr_n;
            id        <= id_n;
            spi_ss    <= ss_n;
            spi_clk   <= sclk_n;
            spi_mosi  <= mosi_n;
            rsp_valid <= rsp_valid_n;
            rsp_id    <= rsp_id_n;
            rsp_data  <= rsp_data_n;
        end
    end

endmodule

// File: tb/tb_dcm_spi_sched.sv
// Directed bench: main config (2 req, D=2, 3 bytes) and a 1-req D=1 1-byte config.
module tb_dcm_spi_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_tot = 0;

    logic [1:0]  a_req_valid = '0;
    logic [1:0]  a_req_ready;
    logic [47:0] a_req_data = '0;
    logic        a_rsp_valid;
    logic [0:0]  a_rsp_id;
    logic [23:0] a_rsp_data;
    logic        a_ss, a_clk, a_mosi, a_miso;
    logic        a_loop = 1'b0;

    logic [0:0]  b_req_valid = '0;
    logic [0:0]  b_req_ready;
    logic [7:0]  b_req_data = '0;
    logic        b_rsp_valid;
    logic [0:0]  b_rsp_id;
    logic [7:0]  b_rsp_data;
    logic        b_ss, b_clk, b_mosi;

    assign a_miso = a_loop ? a_mosi : 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dcm_spi_sched #(.N_REQ(2), .N_BYTES(3), .CLK_DIV(2)) u_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_data  (a_req_data),
        .rsp_valid (a_rsp_valid),
        .rsp_id    (a_rsp_id),
        .rsp_data  (a_rsp_data),
        .spi_ss    (a_ss),
        .spi_clk   (a_clk),
        .spi_mosi  (a_mosi),
        .spi_miso  (a_miso)
    );

    dcm_spi_sched #(.N_REQ(1), .N_BYTES(1), .CLK_DIV(1)) u_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_data  (b_req_data),
        .rsp_valid (b_rsp_valid),
        .rsp_id    (b_rsp_id),
        .rsp_data  (b_rsp_data),
        .spi_ss    (b_ss),
        .spi_clk   (b_clk),
        .spi_mosi  (b_mosi),
        .spi_miso  (b_mosi)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        int          r;
        logic [23:0] frame;
        bit          lb;
        logic [23:0] exp;
    } vec_t;

    vec_t vt[5];

    task automatic send(input vec_t v);
        int          k, t0, rt, ssl;
        bit          got, pclk;
        logic [23:0] bits;
        a_loop = v.lb;
        @(negedge clk);
        a_req_data[v.r*24 +: 24] = v.frame;
        a_req_valid = '0;
        a_req_valid[v.r] = 1'b1;
        #1;
        k = 0;
        while (!a_req_ready[v.r] && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("hs_wait", 32'(k < 300), 1);
        t0 = cyc;
        @(negedge clk);
        a_req_valid = '0;
        k = 0; got = 0; pclk = 0; ssl = 0; bits = '0; rt = 0;
        while (!got && k < 200) begin
            if (!a_ss) ssl++;
            if (a_clk && !pclk) bits = {bits[22:0], a_mosi};
            pclk = a_clk;
            if (a_rsp_valid) begin
                got = 1;
                rt = cyc;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk("rsp_seen", 32'(got), 1);
        chk("ss_low_cycles", ssl, 98);
        chk("rsp_latency", rt - t0, 99);
        chk("mosi_bits", bits, v.frame);
        chk("rsp_id", a_rsp_id, v.r);
        chk("rsp_data", a_rsp_data, v.exp);
        chk("ss_high_at_rsp", a_ss, 1);
        @(negedge clk);
        chk("rsp_pulse_1cyc", a_rsp_valid, 0);
        chk("rsp_data_hold", a_rsp_data, v.exp);
    endtask

    initial begin
        int          k, nhs, viol, norsp, t0, rt, ssl;
        int          hs_t[4];
        int          hs_id[4];
        bit          got, pclk;
        logic [16:0] pat;
        logic [7:0]  bits;
        logic [7:0]  bfr[2];

        vt[0] = '{0, 24'hA53C0F, 1'b0, 24'hFFFFFF};
        vt[1] = '{0, 24'h123456, 1'b1, 24'h123456};
        vt[2] = '{1, 24'h5AC3E7, 1'b1, 24'h5AC3E7};
        vt[3] = '{1, 24'h000001, 1'b0, 24'hFFFFFF};
        vt[4] = '{1, 24'hFEDCBA, 1'b1, 24'hFEDCBA};

        repeat (3) @(negedge clk);
        chk("rst_ss", a_ss, 1);
        chk("rst_clk", a_clk, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_rsp_id", a_rsp_id, 0);
        chk("rst_rsp_data", a_rsp_data, 0);
        chk("rst_b_ss", b_ss, 1);
        reset = 1'b0;

        foreach (vt[i]) send(vt[i]);

        // Both requesters held valid: grants alternate at minimum spacing.
        @(negedge clk);
        a_req_data = {24'h0F0F0F, 24'hF0F0F0};
        a_req_valid = 2'b11;
        nhs = 0; viol = 0; k = 0;
        while (nhs < 4 && k < 600) begin
            #1;
            if ($countones(a_req_ready) > 1) viol++;
            if (!a_ss && a_req_ready != 2'b00) viol++;
            if (|a_req_ready) begin
                hs_id[nhs] = int'(a_req_ready[1]);
                hs_t[nhs] = cyc;
                nhs++;
            end
            @(negedge clk);
            k++;
        end
        a_req_valid = '0;
        chk("alt_count", nhs, 4);
        chk("alt_ready_onehot", viol, 0);
        for (int i = 0; i < 4; i++) chk("alt_grant", hs_id[i], i % 2);
        for (int i = 1; i < 4; i++) chk("alt_spacing", hs_t[i] - hs_t[i-1], 101);
        repeat (110) @(negedge clk);

        // Abort a req0 frame at bit 10 with reset.
        a_loop = 1'b1;
        a_req_data[23:0] = 24'hC33C5A;
        a_req_valid = 2'b01;
        #1;
        chk("abort_ready", a_req_ready, 2'b01);
        t0 = cyc;
        @(negedge clk);
        a_req_valid = '0;
        norsp = 0;
        repeat (42) begin
            if (a_rsp_valid) norsp++;
            @(negedge clk);
        end
        chk("abort_at_bit10", cyc - t0, 43);
        chk("abort_pre_ss", a_ss, 0);
        chk("abort_pre_clk", a_clk, 1);
        chk("abort_pre_mosi", a_mosi, 1);
        reset = 1'b1;
        #1;
        chk("abort_ss", a_ss, 1);
        chk("abort_clk", a_clk, 0);
        chk("abort_mosi", a_mosi, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (110) begin
            if (a_rsp_valid) norsp++;
            @(negedge clk);
        end
        chk("abort_no_rsp", norsp, 0);
        chk("abort_rsp_id", a_rsp_id, 0);
        chk("abort_rsp_data", a_rsp_data, 0);
        a_req_valid = 2'b11;
        #1;
        chk("post_rst_prio", a_req_ready, 2'b01);
        a_req_valid = '0;
        repeat (5) @(negedge clk);
        chk("drop_valid_no_xfer", a_ss, 1);

        // Single requester, D=1, one byte, loopback.
        bfr[0] = 8'h81;
        bfr[1] = 8'h3C;
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            b_req_data = bfr[f];
            b_req_valid = 1'b1;
            #1;
            chk("b_ready", b_req_ready, 1);
            t0 = cyc;
            @(negedge clk);
            b_req_valid = 1'b0;
            k = 0; got = 0; pclk = 0; ssl = 0; pat = '0; bits = '0; rt = 0;
            while (!got && k < 60) begin
                if (!b_ss) begin
                    ssl++;
                    pat = {pat[15:0], b_clk};
                end
                if (b_clk && !pclk) bits = {bits[6:0], b_mosi};
                pclk = b_clk;
                if (b_rsp_valid) begin
                    got = 1;
                    rt = cyc;
                end else begin
                    @(negedge clk);
                    k++;
                end
            end
            chk("b_rsp_seen", 32'(got), 1);
            chk("b_ss_low", ssl, 17);
            chk("b_clk_pattern", pat, 17'h0AAAA);
            chk("b_latency", rt - t0, 18);
            chk("b_mosi_bits", bits, bfr[f]);
            chk("b_rsp_data", b_rsp_data, bfr[f]);
            chk("b_rsp_id", b_rsp_id, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
